// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: round counts, FSM encoding and GF(2^8) helpers.
package aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // byte i sits at bits [127-8i -: 8]; byte i is row i%4, column i/4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Ciphertext-in / plaintext-out valid-ready handshake bundle for the inverse cipher core.
interface aes_inv_cipher_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion (x^254).
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    logic [7:0] t, x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;

    always_comb begin
        t    = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
        // 0 maps to 0 naturally, so no special case is needed for the inverse
        x2   = gf_mul(t, t);
        x3   = gf_mul(x2, t);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, t);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, t);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, t);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, t);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, t);
        y    = gf_mul(x127, x127);
    end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched by index each cycle.
// Build option AES_INV_ZEROIZE_EN: wipe the plaintext on hand-off and mask out_block when not valid.
//
// state    | meaning
// ST_IDLE  | waiting for a ciphertext block; rk_idx = NR for the initial key add
// ST_ROUND | one inverse round per cycle, rk_idx = round counter
// ST_DONE  | plaintext presented until out_ready
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_inv_cipher_iter_if.slave bus,
    output logic [3:0]           rk_idx,
    input  logic [127:0]         rk,
    output logic                 busy
);
    state_t       st, st_nxt;
    logic [127:0] blk, blk_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [127:0] sub_in, sub_out, round_xor;
    logic         in_ready, out_valid;

    assign sub_in = inv_shift_rows(blk);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a(sub_in[127-8*i -: 8]),
            .y(sub_out[127-8*i -: 8])
        );
    end

    assign round_xor = sub_out ^ rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= ST_IDLE;
            blk <= '0;
            cnt <= '0;
        end else begin
            st  <= st_nxt;
            blk <= blk_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        st_nxt    = st;
        blk_nxt   = blk;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = 4'(NR);
        case (st)
            ST_IDLE: begin
                in_ready = !rst;
                if (bus.in_valid) begin
                    blk_nxt = bus.in_block ^ rk;
                    cnt_nxt = 4'(NR - 1);
                    st_nxt  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy   = 1'b1;
                rk_idx = cnt;
                if (cnt != 4'd0) begin
                    blk_nxt = inv_mix_columns(round_xor);
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    blk_nxt = round_xor;
                    st_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                rk_idx    = 4'd0;
                if (bus.out_ready) begin
                    st_nxt = ST_IDLE;
`ifdef AES_INV_ZEROIZE_EN
                    blk_nxt = '0;
`endif
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
`ifdef AES_INV_ZEROIZE_EN
    assign bus.out_block = out_valid ? blk : '0;
`else
    assign bus.out_block = blk;
`endif
endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES decryption core: the inverse counterpart of the encryption round datapath. It applies InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns one round per clock, and sits between the ciphertext source and the plaintext sink. Round keys come from an external key-schedule store through a same-cycle index/data lookup port. Blocks flow through valid/ready handshakes on both sides.

## Interface
- NR, default 10: number of rounds; legal values 10, 12, 14 (AES-128/192/256).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  core can accept a block.
- in_block  in  128  ciphertext; byte i = bits [127-8i -: 8], column-major (byte i is row i%4, column i/4).
- rk_idx  out  4  round-key index requested.
- rk  in  128  round key for rk_idx, valid combinationally in the same cycle; same byte order as in_block.
- out_valid  out  1  plaintext available.
- out_ready  in  1  sink accepts the plaintext.
- out_block  out  128  plaintext; same byte order as in_block.
- busy  out  1  high in ROUND or DONE.

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid&in_ready: state <= in_block ^ rk, round counter <= NR-1, go to ROUND.
- ROUND, with rk_idx = counter:
  - Counter ≥1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk), then decrement the counter.
  - Counter =0: state <= InvSubBytes(InvShiftRows(state)) ^ rk, go to DONE.
- DONE:
  - out_valid=1, out_block=state, rk_idx=0.
  - On out_ready: go to IDLE.
- InvShiftRows: output byte (row r, col c) = input byte (row r, col (c-r) mod 4); row 0 unchanged.
- InvMixColumns: per column, matrix {0e,0b,0d,09} circulant over GF(2^8), reduction polynomial 0x11b.
- in_ready is low in ROUND and DONE. A block offered then waits; it is never dropped.
- Reset (any state, including mid-round):
  - Next state IDLE; state register and counter cleared to 0.
  - out_valid=0, busy=0, rk_idx=NR.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst deasserts.

## Timing
- Handshake accepted on edge k. Rounds execute on edges k+1..k+NR. out_valid is high from edge k+NR.
- Latency: NR cycles from input handshake to out_valid.
- out_block is stable while out_valid=1 and out_ready=0.
- Minimum block period: NR+2 cycles. DONE→IDLE takes one edge, and accept takes one edge.
- rk is sampled in the same cycle rk_idx is driven. The key store must be combinational or hold the key for that cycle.
- Reset values: in_ready=0 (during rst), out_valid=0, busy=0, rk_idx=NR, out_block=0.

## Configuration
- AES_INV_ZEROIZE_EN defined:
  - The state register clears to 0 on the edge of the output handshake.
  - out_block is forced to 0 whenever out_valid=0.
- AES_INV_ZEROIZE_EN undefined:
  - The state register keeps the last plaintext until the next accept.
  - out_block = state at all times.

## Structure
- Shared package aes_pkg holds:
  - NR constants for 128/192/256.
  - FSM state enum.
  - functions: xtime, gf_mul, inv_shift_rows, inv_mix_columns.
- Sub-module aes_inv_sbox: combinational 8-bit inverse S-box, instantiated 16 times for InvSubBytes.

## Test plan
- FIPS-197 C.1, out_ready held high:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, key schedule of 000102030405060708090a0b0c0d0e0f.
  - Response: out_block=00112233445566778899aabbccddeeff; out_valid first high exactly 10 cycles after the handshake, high for 1 cycle.
- FIPS-197 Appendix B:
  - Stimulus: ciphertext 3925841d02dc09fbdc118597196a0b32, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Response: out_block=3243f6a8885a308d313198a2e0370734; rk_idx sequence 10,9,…,1,0 on consecutive cycles.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles after out_valid rises.
  - Response: out_valid and out_block held constant; in_ready=0 and busy=1 throughout.
- Back-to-back blocks:
  - Stimulus: Appendix B then C.1, with in_valid high continuously and out_ready high.
  - Response: second handshake 12 cycles after the first; both plaintexts correct and in order.
- Reset mid-operation:
  - Stimulus: rst for 1 cycle while rk_idx=5.
  - Response: next cycle out_valid=0, busy=0, rk_idx=10, in_ready=1; a following C.1 block decrypts correctly.
- With AES_INV_ZEROIZE_EN:
  - Response: out_block=0 in the cycle after the output handshake and before any accept.
  - Without the macro: out_block still shows the last plaintext in that cycle.
